riscv_trap_sequencer: RTL and testbench
=======================================

RISCV_TRAP_SEQUENCER -- requirements
Module: riscv_trap_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width (32 or 64).
REQ-002 SHALL have parameter MTVEC_INIT, default 'h100, mtvec reset value.
REQ-003 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-004 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port req_valid_i  input  1  retiring instruction presented.
REQ-006 SHALL have port req_ready_o  output  1  sequencer accepts request.
REQ-007 SHALL have port req_pc_i  input  XLEN  pc of presented instruction.
REQ-008 SHALL have port req_tval_i  input  XLEN  fault address/instruction bits.
REQ-009 SHALL have port req_exceptions_i  input  20  exceptions_t vector, bit n = cause n.
REQ-010 SHALL have port req_mret_i  input  1  presented instruction is MRET.
REQ-011 SHALL have port irq_i  input  3  {meip,mtip,msip} pending lines.
REQ-012 SHALL have port csr_we_i  input  1  CSR write strobe.
REQ-013 SHALL have port csr_addr_i  input  12  CSR address (MSTATUS, MIE, MTVEC, MEPC, MCAUSE, MTVAL).
REQ-014 SHALL have port csr_wdata_i  input  XLEN  CSR write data.
REQ-015 SHALL have port csr_rdata_o  output  XLEN  combinational read of csr_addr_i; 0 for unmapped.
REQ-016 SHALL have port redir_valid_o  output  1  pc redirect request to fetch.
REQ-017 SHALL have port redir_ready_i  input  1  fetch accepts redirect.
REQ-018 SHALL have port redir_pc_o  output  XLEN  redirect target.
REQ-019 SHALL have port prv_o  output  2  current privilege (PRV_M/PRV_U).

Function
REQ-020 SHALL implement FSM IDLE -> CAPTURE -> REDIRECT -> IDLE; req_ready_o high only in IDLE.
REQ-021 SHALL, in IDLE on req_valid_i with any exception bit, latch cause/pc/tval and go to CAPTURE.
REQ-022 SHALL, in IDLE, take interrupt when (irq_i & {mie.meie,mie.mtie,mie.msie}) nonzero and (mstatus.mie or prv_o==PRV_U), only on a req_valid_i cycle, without exceptions; mepc = req_pc_i.
REQ-023 SHALL prioritise exceptions over interrupts; exception priority: 3,12,1,2,0,8,11,4,6,13,15,5,7,18,19; interrupt priority MEI(11) > MSI(3) > MTI(7).
REQ-024 SHALL, in CAPTURE (one cycle), write mepc={pc[XLEN-1:1],0}, mcause={intr,cause zero-extended}, mtval=tval (0 for interrupts/ecall), mpie<=mie, mie<=0, mpp<=prv, prv<=PRV_M.
REQ-025 SHALL compute target = {mtvec[XLEN-1:2],00}, plus 4*cause when mtvec[1:0]==01 and interrupt; mtvec[1:0]>=10 written as 00.
REQ-026 SHALL, on req_valid_i with req_mret_i and no exception in IDLE: target=mepc, mie<=mpie, mpie<=1, prv<=mpp, mpp<=PRV_U, go directly to REDIRECT.
REQ-027 SHALL hold redir_valid_o and redir_pc_o stable in REDIRECT until redir_ready_i; return to IDLE on the handshake cycle.
REQ-028 SHALL give trap/mret register updates priority over csr_we_i in the same cycle; the CSR write is dropped.
REQ-029 SHALL treat MRET from PRV_U as illegal instruction (cause 2, tval 0).
REQ-030 SHALL hardwire mpp to legal values only (01/10 written -> PRV_U retained value unchanged).
REQ-031 SHALL ignore irq_i changes after leaving IDLE; trap latency request-to-redir_valid_o = 2 cycles (exception/interrupt), 1 cycle (mret).

Reset
REQ-032 SHALL asynchronously on rst_ni low: FSM IDLE, prv_o=PRV_M, mie=mpie=0, mpp=PRV_M, mtvec=MTVEC_INIT, mepc=mcause=mtval=0, mie-register=0, redir_valid_o=0, redir_pc_o=0.
REQ-033 SHALL abort any in-progress sequence on reset mid-CAPTURE/REDIRECT with no partial CSR update retained.

Verification
REQ-034 SHALL verify: illegal (bit2) at pc 'h200, tval 'hDEAD, mtvec 'h100 -> 2 cycles later redir_pc_o='h100, mcause=2, mepc='h200, mtval='hDEAD, mie=0.
REQ-035 SHALL verify: mtvec='h101, mstatus.mie=1, meie=1, irq_i=100 -> redir_pc_o='h12C, mcause='h8000000B.
REQ-036 SHALL verify: bits 3 and 2 set together -> mcause=3; exception plus pending interrupt -> exception taken.
REQ-037 SHALL verify: mret with mepc='h400, mpie=1, mpp=U -> redir_pc_o='h400 next cycle, mie=1, prv_o=U, mpp=U.
REQ-038 SHALL verify: redir_ready_i low 5 cycles -> redir_valid_o/redir_pc_o stable, req_ready_o=0 throughout.
REQ-039 SHALL verify: rst_ni low during REDIRECT -> redir_valid_o=0 immediately, prv_o=M, mtvec=MTVEC_INIT.

Source files
------------

// File: rtl/riscv_trap_sequencer.sv
// Machine-mode trap sequencer: turns exceptions, interrupts and MRET on the
// retiring instruction into trap-CSR updates and a fetch redirect.
module riscv_trap_sequencer #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] MTVEC_INIT = 'h100
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [XLEN-1:0] req_pc_i,
  input  logic [XLEN-1:0] req_tval_i,
  input  logic [19:0]     req_exceptions_i,
  input  logic            req_mret_i,
  input  logic [2:0]      irq_i,
  input  logic            csr_we_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            redir_valid_o,
  input  logic            redir_ready_i,
  output logic [XLEN-1:0] redir_pc_o,
  output logic [1:0]      prv_o
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam logic [1:0] PRV_U = 2'b00;
  localparam logic [1:0] PRV_M = 2'b11;

  localparam int unsigned NUM_PRIO = 15;
  localparam logic [4:0] EXC_PRIO [NUM_PRIO] = '{
    5'd3, 5'd12, 5'd1, 5'd2, 5'd0, 5'd8, 5'd11, 5'd4,
    5'd6, 5'd13, 5'd15, 5'd5, 5'd7, 5'd18, 5'd19
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_REDIRECT
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      prv_q, prv_d;
  logic            mstatus_mie_q, mstatus_mie_d;
  logic            mstatus_mpie_q, mstatus_mpie_d;
  logic [1:0]      mstatus_mpp_q, mstatus_mpp_d;
  logic            meie_q, meie_d;
  logic            mtie_q, mtie_d;
  logic            msie_q, msie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;
  logic [4:0]      cause_q, cause_d;
  logic            intr_q, intr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tval_q, tval_d;

  logic [19:0]     exc_vec;
  logic            exc_any;
  logic [4:0]      exc_cause;
  logic            exc_no_tval;
  logic [2:0]      irq_en;
  logic            irq_take;
  logic [4:0]      irq_cause;
  logic            take_exc, take_irq, take_mret;
  logic            csr_wr;
  logic [XLEN-1:0] trap_base;
  logic [XLEN-1:0] trap_target;

  // Unlisted cause bits fall back to lowest index; the listed order then
  // overrides, scanned backwards so the highest-priority set bit wins last.
  function automatic logic [4:0] pick_exception(input logic [19:0] exc);
    logic [4:0] cause;
    cause = 5'd0;
    for (int i = 19; i >= 0; i--) begin
      if (exc[i]) cause = 5'(i);
    end
    for (int i = NUM_PRIO - 1; i >= 0; i--) begin
      if (exc[EXC_PRIO[i]]) cause = EXC_PRIO[i];
    end
    return cause;
  endfunction

  always_comb begin
    exc_vec    = req_exceptions_i;
    exc_vec[2] = req_exceptions_i[2] | (req_mret_i & (prv_q == PRV_U));
    exc_any    = |exc_vec;
    exc_cause  = pick_exception(exc_vec);
    // MRET from user mode raises illegal-instruction with a zero tval.
    exc_no_tval = (exc_cause == 5'd8) || (exc_cause == 5'd9) || (exc_cause == 5'd11) ||
                  ((exc_cause == 5'd2) && !req_exceptions_i[2]);

    irq_en   = irq_i & {meie_q, mtie_q, msie_q};
    irq_take = (|irq_en) && (mstatus_mie_q || (prv_q == PRV_U));
    if (irq_en[2])      irq_cause = 5'd11;
    else if (irq_en[0]) irq_cause = 5'd3;
    else                irq_cause = 5'd7;

    take_exc  = (state_q == S_IDLE) && req_valid_i && exc_any;
    take_irq  = (state_q == S_IDLE) && req_valid_i && !exc_any && irq_take;
    take_mret = (state_q == S_IDLE) && req_valid_i && !exc_any && !irq_take && req_mret_i;

    csr_wr = csr_we_i && (state_q != S_CAPTURE) && !(take_exc || take_irq || take_mret);

    trap_base = {mtvec_q[XLEN-1:2], 2'b00};
    if ((mtvec_q[1:0] == 2'b01) && intr_q) begin
      trap_target = trap_base + {{(XLEN-7){1'b0}}, cause_q, 2'b00};
    end else begin
      trap_target = trap_base;
    end
  end

  always_comb begin
    // NOTE: every next-state signal is defaulted to its register first so no
    // path through the case/if tree leaves it unassigned and infers a latch.
    state_d        = state_q;
    prv_d          = prv_q;
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mstatus_mpp_d  = mstatus_mpp_q;
    meie_d         = meie_q;
    mtie_d         = mtie_q;
    msie_d         = msie_q;
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    redir_pc_d     = redir_pc_q;
    cause_d        = cause_q;
    intr_d         = intr_q;
    pc_d           = pc_q;
    tval_d         = tval_q;

    if (csr_wr) begin
      unique case (csr_addr_i)
        CSR_MSTATUS: begin
          mstatus_mie_d  = csr_wdata_i[3];
          mstatus_mpie_d = csr_wdata_i[7];
          if ((csr_wdata_i[12:11] == PRV_U) || (csr_wdata_i[12:11] == PRV_M)) begin
            mstatus_mpp_d = csr_wdata_i[12:11];
          end
        end
        CSR_MIE: begin
          meie_d = csr_wdata_i[11];
          mtie_d = csr_wdata_i[7];
          msie_d = csr_wdata_i[3];
        end
        CSR_MTVEC:  mtvec_d  = {csr_wdata_i[XLEN-1:2], 1'b0, (csr_wdata_i[1:0] == 2'b01)};
        CSR_MEPC:   mepc_d   = {csr_wdata_i[XLEN-1:1], 1'b0};
        CSR_MCAUSE: mcause_d = csr_wdata_i;
        CSR_MTVAL:  mtval_d  = csr_wdata_i;
        default: ;
      endcase
    end

    unique case (state_q)
      S_IDLE: begin
        if (take_exc) begin
          cause_d = exc_cause;
          intr_d  = 1'b0;
          pc_d    = req_pc_i;
          tval_d  = exc_no_tval ? '0 : req_tval_i;
          state_d = S_CAPTURE;
        end else if (take_irq) begin
          cause_d = irq_cause;
          intr_d  = 1'b1;
          pc_d    = req_pc_i;
          tval_d  = '0;
          state_d = S_CAPTURE;
        end else if (take_mret) begin
          redir_pc_d     = mepc_q;
          mstatus_mie_d  = mstatus_mpie_q;
          mstatus_mpie_d = 1'b1;
          prv_d          = mstatus_mpp_q;
          mstatus_mpp_d  = PRV_U;
          state_d        = S_REDIRECT;
        end
      end
      S_CAPTURE: begin
        mepc_d         = {pc_q[XLEN-1:1], 1'b0};
        mcause_d       = {intr_q, {(XLEN-6){1'b0}}, cause_q};
        mtval_d        = tval_q;
        mstatus_mpie_d = mstatus_mie_q;
        mstatus_mie_d  = 1'b0;
        mstatus_mpp_d  = prv_q;
        prv_d          = PRV_M;
        redir_pc_d     = trap_target;
        state_d        = S_REDIRECT;
      end
      S_REDIRECT: begin
        if (redir_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= S_IDLE;
      prv_q          <= PRV_M;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mstatus_mpp_q  <= PRV_M;
      meie_q         <= 1'b0;
      mtie_q         <= 1'b0;
      msie_q         <= 1'b0;
      mtvec_q        <= MTVEC_INIT;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      redir_pc_q     <= '0;
      cause_q        <= '0;
      intr_q         <= 1'b0;
      pc_q           <= '0;
      tval_q         <= '0;
    end else begin
      state_q        <= state_d;
      prv_q          <= prv_d;
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mstatus_mpp_q  <= mstatus_mpp_d;
      meie_q         <= meie_d;
      mtie_q         <= mtie_d;
      msie_q         <= msie_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
      redir_pc_q     <= redir_pc_d;
      cause_q        <= cause_d;
      intr_q         <= intr_d;
      pc_q           <= pc_d;
      tval_q         <= tval_d;
    end
  end

  always_comb begin
    csr_rdata_o = '0;
    unique case (csr_addr_i)
      CSR_MSTATUS: begin
        csr_rdata_o[3]     = mstatus_mie_q;
        csr_rdata_o[7]     = mstatus_mpie_q;
        csr_rdata_o[12:11] = mstatus_mpp_q;
      end
      CSR_MIE: begin
        csr_rdata_o[11] = meie_q;
        csr_rdata_o[7]  = mtie_q;
        csr_rdata_o[3]  = msie_q;
      end
      CSR_MTVEC:  csr_rdata_o = mtvec_q;
      CSR_MEPC:   csr_rdata_o = mepc_q;
      CSR_MCAUSE: csr_rdata_o = mcause_q;
      CSR_MTVAL:  csr_rdata_o = mtval_q;
      default: ;
    endcase
  end

  assign req_ready_o   = (state_q == S_IDLE);
  assign redir_valid_o = (state_q == S_REDIRECT);
  assign redir_pc_o    = redir_pc_q;
  assign prv_o         = prv_q;

endmodule

// File: tb/tb_riscv_trap_sequencer.sv
// Directed bench for riscv_trap_sequencer: traps, interrupts, MRET, CSR write
// legalisation, redirect backpressure and reset abort.
module tb_riscv_trap_sequencer;

  localparam logic [11:0] MSTATUS = 12'h300;
  localparam logic [11:0] MIE     = 12'h304;
  localparam logic [11:0] MTVEC   = 12'h305;
  localparam logic [11:0] MEPC    = 12'h341;
  localparam logic [11:0] MCAUSE  = 12'h342;
  localparam logic [11:0] MTVAL   = 12'h343;

  logic        clk_i, rst_ni;
  logic        req_valid_i, req_ready_o, req_mret_i;
  logic [31:0] req_pc_i, req_tval_i;
  logic [19:0] req_exceptions_i;
  logic [2:0]  irq_i;
  logic        csr_we_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i, csr_rdata_o;
  logic        redir_valid_o, redir_ready_i;
  logic [31:0] redir_pc_o;
  logic [1:0]  prv_o;

  int n_errors = 0;
  int n_checks = 0;

  riscv_trap_sequencer #(.XLEN(32), .MTVEC_INIT(32'h100)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_pc_i(req_pc_i), .req_tval_i(req_tval_i),
    .req_exceptions_i(req_exceptions_i), .req_mret_i(req_mret_i),
    .irq_i(irq_i),
    .csr_we_i(csr_we_i), .csr_addr_i(csr_addr_i),
    .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o),
    .redir_valid_o(redir_valid_o), .redir_ready_i(redir_ready_i),
    .redir_pc_o(redir_pc_o), .prv_o(prv_o)
  );

  initial clk_i = 1'b0;
  always #50 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; req_valid_i = 1'b0; req_mret_i = 1'b0;
    req_pc_i = '0; req_tval_i = '0; req_exceptions_i = '0; irq_i = '0;
    csr_we_i = 1'b0; csr_addr_i = '0; csr_wdata_i = '0; redir_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    step();
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    csr_we_i = 1'b1; csr_addr_i = addr; csr_wdata_i = data;
    step();
    csr_we_i = 1'b0;
  endtask

  task automatic csr_read(input logic [11:0] addr, output logic [31:0] data);
    csr_addr_i = addr;
    #1 data = csr_rdata_o;
  endtask

  task automatic present(input logic [31:0] pc, input logic [31:0] tval,
                         input logic [19:0] exc, input logic mret);
    req_valid_i = 1'b1; req_pc_i = pc; req_tval_i = tval;
    req_exceptions_i = exc; req_mret_i = mret;
    step();
    req_valid_i = 1'b0; req_exceptions_i = '0; req_mret_i = 1'b0;
  endtask

  task automatic finish_redirect();
    redir_ready_i = 1'b1;
    step();
    redir_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    do_reset();
    n_checks++; if (req_ready_o !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %0b exp 1", req_ready_o); end
    n_checks++; if (redir_valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_redir_valid: got %0b exp 0", redir_valid_o); end
    n_checks++; if (redir_pc_o !== 32'h0) begin n_errors++; $display("FAIL reset_redir_pc: got %h exp 0", redir_pc_o); end
    n_checks++; if (prv_o !== 2'b11) begin n_errors++; $display("FAIL reset_prv: got %b exp 11", prv_o); end
    csr_read(MTVEC, r);
    n_checks++; if (r !== 32'h100) begin n_errors++; $display("FAIL reset_mtvec: got %h exp 100", r); end
    csr_read(MSTATUS, r);
    n_checks++; if (r !== 32'h1800) begin n_errors++; $display("FAIL reset_mstatus: got %h exp 1800", r); end
    csr_read(MIE, r);
    n_checks++; if (r !== 32'h0) begin n_errors++; $display("FAIL reset_mie: got %h exp 0", r); end
    csr_read(MCAUSE, r);
    n_checks++; if (r !== 32'h0) begin n_errors++; $display("FAIL reset_mcause: got %h exp 0", r); end
    csr_read(MEPC, r);
    n_checks++; if (r !== 32'h0) begin n_errors++; $display("FAIL reset_mepc: got %h exp 0", r); end
  endtask

  task automatic test_illegal();
    logic [31:0] r;
    do_reset();
    csr_write(MSTATUS, 32'h1808);
    n_checks++; if (req_ready_o !== 1'b1) begin n_errors++; $display("FAIL ill_ready: got %0b exp 1", req_ready_o); end
    present(32'h200, 32'hDEAD, 20'h00004, 1'b0);
    n_checks++; if (redir_valid_o !== 1'b0) begin n_errors++; $display("FAIL ill_capture_valid: got %0b exp 0", redir_valid_o); end
    n_checks++; if (req_ready_o !== 1'b0) begin n_errors++; $display("FAIL ill_capture_ready: got %0b exp 0", req_ready_o); end
    step();
    n_checks++; if (redir_valid_o !== 1'b1) begin n_errors++; $display("FAIL ill_redir_valid: got %0b exp 1", redir_valid_o); end
    n_checks++; if (redir_pc_o !== 32'h100) begin n_errors++; $display("FAIL ill_redir_pc: got %h exp 100", redir_pc_o); end
    csr_read(MCAUSE, r);
    n_checks++; if (r !== 32'h2) begin n_errors++; $display("FAIL ill_mcause: got %h exp 2", r); end
    csr_read(MEPC, r);
    n_checks++; if (r !== 32'h200) begin n_errors++; $display("FAIL ill_mepc: got %h exp 200", r); end
    csr_read(MTVAL, r);
    n_checks++; if (r !== 32'hDEAD) begin n_errors++; $display("FAIL ill_mtval: got %h exp dead", r); end
    csr_read(MSTATUS, r);
    n_checks++; if (r !== 32'h1880) begin n_errors++; $display("FAIL ill_mstatus: got %h exp 1880", r); end
    finish_redirect();
    n_checks++; if (req_ready_o !== 1'b1 || redir_valid_o !== 1'b0) begin n_errors++; $display("FAIL ill_return_idle: ready=%0b valid=%0b exp 1/0", req_ready_o, redir_valid_o); end
  endtask

  task automatic test_vectored_irq();
    logic [31:0] r;
    do_reset();
    csr_write(MTVEC, 32'h101);
    csr_write(MIE, 32'h800);
    csr_write(MSTATUS, 32'h1808);
    csr_read(MTVEC, r);
    n_checks++; if (r !== 32'h101) begin n_errors++; $display("FAIL irq_mtvec_rd: got %h exp 101", r); end
    irq_i = 3'b100;
    step();
    n_checks++; if (req_ready_o !== 1'b1) begin n_errors++; $display("FAIL irq_no_req_taken: ready=%0b exp 1", req_ready_o); end
    present(32'h300, 32'h55, 20'h0, 1'b0);
    irq_i = 3'b000;
    n_checks++; if (redir_valid_o !== 1'b0) begin n_errors++; $display("FAIL irq_capture_valid: got %0b exp 0", redir_valid_o); end
    step();
    n_checks++; if (redir_valid_o !== 1'b1) begin n_errors++; $display("FAIL irq_redir_valid: got %0b exp 1", redir_valid_o); end
    n_checks++; if (redir_pc_o !== 32'h12C) begin n_errors++; $display("FAIL irq_redir_pc: got %h exp 12c", redir_pc_o); end
    csr_read(MCAUSE, r);
    n_checks++; if (r !== 32'h8000000B) begin n_errors++; $display("FAIL irq_mcause: got %h exp 8000000b", r); end
    csr_read(MEPC, r);
    n_checks++; if (r !== 32'h300) begin n_errors++; $display("FAIL irq_mepc: got %h exp 300", r); end
    csr_read(MTVAL, r);
    n_checks++; if (r !== 32'h0) begin n_errors++; $display("FAIL irq_mtval: got %h exp 0", r); end
    finish_redirect();
  endtask

  task automatic test_priority();
    logic [31:0] r;
    do_reset();
    csr_write(MTVEC, 32'h101);
    csr_write(MIE, 32'h888);
    csr_write(MSTATUS, 32'h1808);
    irq_i = 3'b100;
    present(32'h40, 32'h11, 20'h0000C, 1'b0);
    step();
    csr_read(MCAUSE, r);
    n_checks++; if (r !== 32'h3) begin n_errors++; $display("FAIL prio_3_over_2: got %h exp 3", r); end
    n_checks++; if (redir_pc_o !== 32'h100) begin n_errors++; $display("FAIL prio_exc_base: got %h exp 100", redir_pc_o); end
    finish_redirect();
    csr_write(MSTATUS, 32'h1808);
    present(32'h44, 32'h22, 20'h00020, 1'b0);
    step();
    csr_read(MCAUSE, r);
    n_checks++; if (r !== 32'h5) begin n_errors++; $display("FAIL prio_exc_over_irq: got %h exp 5", r); end
    csr_read(MTVAL, r);
    n_checks++; if (r !== 32'h22) begin n_errors++; $display("FAIL prio_exc_mtval: got %h exp 22", r); end
    finish_redirect();
    irq_i = 3'b000;
    present(32'h48, 32'h33, 20'h00810, 1'b0);
    step();
    csr_read(MCAUSE, r);
    n_checks++; if (r !== 32'hB) begin n_errors++; $display("FAIL prio_ecall_over_4: got %h exp b", r); end
    csr_read(MTVAL, r);
    n_checks++; if (r !== 32'h0) begin n_errors++; $display("FAIL prio_ecall_mtval: got %h exp 0", r); end
    finish_redirect();
    csr_write(MSTATUS, 32'h1808);
    irq_i = 3'b011;
    present(32'h4C, 32'h44, 20'h0, 1'b0);
    irq_i = 3'b000;
    step();
    csr_read(MCAUSE, r);
    n_checks++; if (r !== 32'h80000003) begin n_errors++; $display("FAIL prio_msi_over_mti: got %h exp 80000003", r); end
    n_checks++; if (redir_pc_o !== 32'h10C) begin n_errors++; $display("FAIL prio_msi_vector: got %h exp 10c", redir_pc_o); end
    finish_redirect();
  endtask

  task automatic test_mret();
    logic [31:0] r;
    do_reset();
    csr_write(MEPC, 32'h400);
    csr_write(MSTATUS, 32'h0080);
    csr_we_i = 1'b1; csr_addr_i = MSTATUS; csr_wdata_i = 32'h0;
    present(32'h10, 32'h0, 20'h0, 1'b1);
    csr_we_i = 1'b0;
    n_checks++; if (redir_valid_o !== 1'b1) begin n_errors++; $display("FAIL mret_valid: got %0b exp 1", redir_valid_o); end
    n_checks++; if (redir_pc_o !== 32'h400) begin n_errors++; $display("FAIL mret_pc: got %h exp 400", redir_pc_o); end
    n_checks++; if (prv_o !== 2'b00) begin n_errors++; $display("FAIL mret_prv: got %b exp 00", prv_o); end
    csr_read(MSTATUS, r);
    n_checks++; if (r !== 32'h0088) begin n_errors++; $display("FAIL mret_mstatus: got %h exp 88", r); end
    finish_redirect();
    present(32'h20, 32'h1234, 20'h0, 1'b1);
    n_checks++; if (redir_valid_o !== 1'b0) begin n_errors++; $display("FAIL umret_capture: got %0b exp 0", redir_valid_o); end
    step();
    csr_read(MCAUSE, r);
    n_checks++; if (r !== 32'h2) begin n_errors++; $display("FAIL umret_mcause: got %h exp 2", r); end
    csr_read(MTVAL, r);
    n_checks++; if (r !== 32'h0) begin n_errors++; $display("FAIL umret_mtval: got %h exp 0", r); end
    csr_read(MSTATUS, r);
    n_checks++; if (r !== 32'h0080) begin n_errors++; $display("FAIL umret_mstatus: got %h exp 80", r); end
    n_checks++; if (prv_o !== 2'b11 || redir_pc_o !== 32'h100) begin n_errors++; $display("FAIL umret_prv_pc: prv=%b pc=%h exp 11/100", prv_o, redir_pc_o); end
    finish_redirect();
  endtask

  task automatic test_csr_rules();
    logic [31:0] r;
    do_reset();
    csr_write(MTVEC, 32'h102);
    csr_read(MTVEC, r);
    n_checks++; if (r !== 32'h100) begin n_errors++; $display("FAIL csr_mtvec_mode2: got %h exp 100", r); end
    csr_write(MTVEC, 32'h203);
    csr_read(MTVEC, r);
    n_checks++; if (r !== 32'h200) begin n_errors++; $display("FAIL csr_mtvec_mode3: got %h exp 200", r); end
    csr_write(MSTATUS, 32'h0808);
    csr_read(MSTATUS, r);
    n_checks++; if (r !== 32'h1808) begin n_errors++; $display("FAIL csr_mpp_01: got %h exp 1808", r); end
    csr_write(MSTATUS, 32'h1000);
    csr_read(MSTATUS, r);
    n_checks++; if (r !== 32'h1800) begin n_errors++; $display("FAIL csr_mpp_10: got %h exp 1800", r); end
    csr_write(MSTATUS, 32'h0000);
    csr_read(MSTATUS, r);
    n_checks++; if (r !== 32'h0000) begin n_errors++; $display("FAIL csr_mpp_00: got %h exp 0", r); end
    csr_write(12'h340, 32'hFFFF);
    csr_read(12'h340, r);
    n_checks++; if (r !== 32'h0) begin n_errors++; $display("FAIL csr_unmapped: got %h exp 0", r); end
    csr_write(MEPC, 32'h401);
    csr_read(MEPC, r);
    n_checks++; if (r !== 32'h400) begin n_errors++; $display("FAIL csr_mepc_align: got %h exp 400", r); end
    present(32'h600, 32'h77, 20'h00001, 1'b0);
    csr_we_i = 1'b1; csr_addr_i = MTVAL; csr_wdata_i = 32'hBEEF;
    step();
    csr_we_i = 1'b0;
    csr_read(MTVAL, r);
    n_checks++; if (r !== 32'h77) begin n_errors++; $display("FAIL csr_drop_in_trap: got %h exp 77", r); end
    n_checks++; if (redir_pc_o !== 32'h200) begin n_errors++; $display("FAIL csr_trap_pc: got %h exp 200", redir_pc_o); end
    finish_redirect();
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    do_reset();
    present(32'h700, 32'h1, 20'h00004, 1'b0);
    step();
    req_valid_i = 1'b1; req_pc_i = 32'h900; req_exceptions_i = 20'h00004;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (redir_valid_o !== 1'b1 || redir_pc_o !== 32'h100 || req_ready_o !== 1'b0) begin
        n_errors++; $display("FAIL stall_cycle%0d: valid=%0b pc=%h ready=%0b exp 1/100/0", i, redir_valid_o, redir_pc_o, req_ready_o);
      end
      step();
    end
    req_valid_i = 1'b0; req_exceptions_i = '0;
    n_checks++; if (redir_valid_o !== 1'b1) begin n_errors++; $display("FAIL stall_hold: got %0b exp 1", redir_valid_o); end
    finish_redirect();
    n_checks++; if (redir_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin n_errors++; $display("FAIL stall_release: valid=%0b ready=%0b exp 0/1", redir_valid_o, req_ready_o); end
    csr_read(MEPC, r);
    n_checks++; if (r !== 32'h700) begin n_errors++; $display("FAIL stall_ignored_req: got %h exp 700", r); end
    present(32'h800, 32'h5, 20'h00002, 1'b0);
    step();
    csr_read(MCAUSE, r);
    n_checks++; if (r !== 32'h1) begin n_errors++; $display("FAIL b2b_mcause: got %h exp 1", r); end
    csr_read(MEPC, r);
    n_checks++; if (r !== 32'h800) begin n_errors++; $display("FAIL b2b_mepc: got %h exp 800", r); end
    finish_redirect();
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    do_reset();
    csr_write(MTVEC, 32'h300);
    present(32'h100, 32'hAB, 20'h00004, 1'b0);
    #1 rst_ni = 1'b0;
    #1;
    n_checks++; if (req_ready_o !== 1'b1 || redir_valid_o !== 1'b0) begin n_errors++; $display("FAIL rst_cap_state: ready=%0b valid=%0b exp 1/0", req_ready_o, redir_valid_o); end
    csr_read(MCAUSE, r);
    n_checks++; if (r !== 32'h0) begin n_errors++; $display("FAIL rst_cap_mcause: got %h exp 0", r); end
    csr_read(MTVAL, r);
    n_checks++; if (r !== 32'h0) begin n_errors++; $display("FAIL rst_cap_mtval: got %h exp 0", r); end
    do_reset();
    csr_write(MTVEC, 32'h300);
    csr_write(MEPC, 32'h500);
    csr_write(MSTATUS, 32'h0080);
    present(32'h10, 32'h0, 20'h0, 1'b1);
    n_checks++; if (redir_valid_o !== 1'b1 || prv_o !== 2'b00) begin n_errors++; $display("FAIL rst_red_pre: valid=%0b prv=%b exp 1/00", redir_valid_o, prv_o); end
    #1 rst_ni = 1'b0;
    #1;
    n_checks++; if (redir_valid_o !== 1'b0) begin n_errors++; $display("FAIL rst_red_valid: got %0b exp 0", redir_valid_o); end
    n_checks++; if (redir_pc_o !== 32'h0) begin n_errors++; $display("FAIL rst_red_pc: got %h exp 0", redir_pc_o); end
    n_checks++; if (prv_o !== 2'b11) begin n_errors++; $display("FAIL rst_red_prv: got %b exp 11", prv_o); end
    csr_read(MTVEC, r);
    n_checks++; if (r !== 32'h100) begin n_errors++; $display("FAIL rst_red_mtvec: got %h exp 100", r); end
    csr_read(MSTATUS, r);
    n_checks++; if (r !== 32'h1800) begin n_errors++; $display("FAIL rst_red_mstatus: got %h exp 1800", r); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_illegal();
    test_vectored_irq();
    test_priority();
    test_mret();
    test_csr_rules();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
